instr_mem_loader: RTL

Writer side of the instruction-memory port that the fetch stage only reads (its write enable is tied low there). Accepts a byte stream from the debug/UART path over a valid/ready handshake and assembles 4 bytes per big-endian instruction word. Writes each word into the instruction RAM at consecutive word addresses and stops after the halt word. While loading, `o_busy` holds the pipeline in reset/stall.

---
 rtl/instr_mem_loader.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/instr_mem_loader.sv
// Byte-stream to instruction-RAM loader: packs big-endian words, writes them, stops on HALT_WORD.
// Optional LOADER_CHECKSUM_EN adds a trailing XOR checksum byte check (state CHK).
module instr_mem_loader #(
  parameter int                NB_BITS   = 32,
  parameter int                NB_BYTE   = 8,
  parameter int                RAM_DEPTH = 10,
  parameter logic [NB_BITS-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic [NB_BYTE-1:0]     i_byte,
  input  logic                   i_byte_valid,
  output logic                   o_byte_ready,
  output logic [RAM_DEPTH-3:0]   o_mem_addr,
  output logic [NB_BITS-1:0]     o_mem_data,
  output logic                   o_mem_wea,
  output logic                   o_mem_ena,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_overflow,
  output logic                   o_chk_err,
  output logic [RAM_DEPTH-2:0]   o_word_count
);

  localparam int NB_WADDR       = RAM_DEPTH - 2;
  localparam int BYTES_PER_WORD = NB_BITS / NB_BYTE;
  localparam int NB_BCNT        = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [NB_BCNT-1:0]  LAST_BYTE = NB_BCNT'(BYTES_PER_WORD - 1);
  localparam logic [NB_WADDR-1:0] LAST_ADDR = '1;

  // IDLE wait start | RECV take bytes | WRITE one-cycle RAM write | CHK checksum byte | DONE halt seen | ERR overflow/checksum
  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
`ifdef LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERR
  } state_t;

  state_t                r_state;
  logic [NB_BCNT-1:0]    r_bcnt;
  logic [NB_WADDR-1:0]   r_addr;
  logic [NB_BITS-1:0]    r_word;
  logic [RAM_DEPTH-2:0]  r_word_count;
  logic                  r_byte_ready;
  logic [NB_WADDR-1:0]   r_mem_addr;
  logic [NB_BITS-1:0]    r_mem_data;
  logic                  r_mem_wea;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_overflow;
`ifdef LOADER_CHECKSUM_EN
  logic [NB_BYTE-1:0]    r_xor;
  logic                  r_chk_err;
`endif

  logic                  w_accept;
  logic [NB_BITS-1:0]    w_word_next;

  assign w_accept    = i_byte_valid & r_byte_ready;
  assign w_word_next = {r_word[NB_BITS-NB_BYTE-1:0], i_byte};

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state      <= S_IDLE;
      r_bcnt       <= '0;
      r_addr       <= '0;
      r_word       <= '0;
      r_word_count <= '0;
      r_byte_ready <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_data   <= '0;
      r_mem_wea    <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_overflow   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_xor        <= '0;
      r_chk_err    <= 1'b0;
`endif
    end else begin
      r_mem_wea <= 1'b0;
      if (i_start) begin
        // Restart wins over everything, including a byte offered in the same cycle.
        r_state      <= S_RECV;
        r_bcnt       <= '0;
        r_addr       <= '0;
        r_word       <= '0;
        r_word_count <= '0;
        r_byte_ready <= 1'b1;
        r_busy       <= 1'b1;
        r_done       <= 1'b0;
        r_overflow   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
        r_xor        <= '0;
        r_chk_err    <= 1'b0;
`endif
      end else begin
        case (r_state)
          S_RECV: begin
            if (w_accept) begin
              r_word <= w_word_next;
`ifdef LOADER_CHECKSUM_EN
              r_xor  <= r_xor ^ i_byte;
`endif
              if (r_bcnt == LAST_BYTE) begin
                r_bcnt       <= '0;
                r_state      <= S_WRITE;
                r_byte_ready <= 1'b0;
                r_mem_wea    <= 1'b1;
                r_mem_addr   <= r_addr;
                r_mem_data   <= w_word_next;
              end else begin
                r_bcnt <= r_bcnt + NB_BCNT'(1);
              end
            end
          end
          S_WRITE: begin
            r_word_count <= r_word_count + (RAM_DEPTH-1)'(1);
            if (r_word == HALT_WORD) begin
`ifdef LOADER_CHECKSUM_EN
              r_state      <= S_CHK;
              r_byte_ready <= 1'b1;
`else
              r_state      <= S_DONE;
              r_done       <= 1'b1;
              r_busy       <= 1'b0;
`endif
            end else if (r_addr == LAST_ADDR) begin
              r_state    <= S_ERR;
              r_overflow <= 1'b1;
              r_busy     <= 1'b0;
            end else begin
              r_addr       <= r_addr + NB_WADDR'(1);
              r_state      <= S_RECV;
              r_byte_ready <= 1'b1;
            end
          end
`ifdef LOADER_CHECKSUM_EN
          S_CHK: begin
            if (w_accept) begin
              r_byte_ready <= 1'b0;
              r_busy       <= 1'b0;
              if (i_byte == r_xor) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state   <= S_ERR;
                r_chk_err <= 1'b1;
              end
            end
          end
`endif
          default: begin
          end
        endcase
      end
    end
  end

  assign o_byte_ready = r_byte_ready;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_data   = r_mem_data;
  assign o_mem_wea    = r_mem_wea;
  assign o_mem_ena    = r_mem_wea;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_overflow   = r_overflow;
  assign o_word_count = r_word_count;
`ifdef LOADER_CHECKSUM_EN
  assign o_chk_err    = r_chk_err;
`else
  assign o_chk_err    = 1'b0;
`endif

endmodule
